// File: rtl/scedma_segresp.sv
// Responder end of the scedma segment request/response interface: maps
// segment-relative requests onto a single-port synchronous RAM port.
module scedma_segresp #(
  parameter int AW    = 12,
  parameter int DW    = 32,
  parameter int RDLAT = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] req_segaddr,
  input  logic [AW-1:0] req_segsize,
  input  logic [AW-1:0] req_segptr,
  input  logic          req_segrd,
  input  logic          req_segwr,
  input  logic [DW-1:0] req_segwdat,
  input  logic [1:0]    req_porttype,
  output logic          res_segready,
  output logic [DW-1:0] res_segrdat,
  output logic          res_segrdatvld,
  input  logic          ram_gnt,
  output logic          ram_cs,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdat,
  input  logic [DW-1:0] ram_rdat,
  input  logic          err_clr,
  output logic [1:0]    err_sticky,
  output logic [7:0]    intr
);

  // Port-type encoding: 0 = read-only, 1 = write-only, 2 = read/write.
  localparam logic [1:0] PT_RO = 2'd0;
  localparam logic [1:0] PT_WO = 2'd1;
  localparam int CW = $clog2(RDLAT + 2);
  localparam logic [CW-1:0] MAX_OUT = CW'(RDLAT + 1);

  logic          rd_sel, wr_sel;
  logic          bnd_err, pt_err, any_err;
  logic          full;
  logic          acc_rd, acc_wr, acc;
  logic [1:0]    new_err;
  logic [CW-1:0] outst;
  logic [RDLAT-1:0] vld_p;
  logic [RDLAT-1:0] ezero_p;

  function automatic logic [DW-1:0] resp_data(input logic ezero, input logic [DW-1:0] rdat);
    return ezero ? '0 : rdat;
  endfunction

  // Request decode and acceptance (stage 0, combinational)
  always_comb begin
    rd_sel  = req_segrd;
    wr_sel  = req_segwr & ~req_segrd;
    bnd_err = (req_segptr >= req_segsize);
    pt_err  = (rd_sel & (req_porttype == PT_WO)) | (wr_sel & (req_porttype == PT_RO));
    any_err = (rd_sel | wr_sel) & (bnd_err | pt_err);
    // A return pulse in this cycle frees a slot for a new read.
    full    = (outst == MAX_OUT) & ~res_segrdatvld;
    acc_rd  = ~reset & rd_sel & ~full & (any_err | ram_gnt);
    acc_wr  = ~reset & wr_sel & (any_err | ram_gnt);
    acc     = acc_rd | acc_wr;
    new_err = acc ? {pt_err, bnd_err} : 2'b00;
  end

  assign res_segready = acc;
  assign ram_cs       = acc & ~any_err;
  assign ram_we       = acc_wr & ~any_err;
  assign ram_addr     = req_segaddr + req_segptr;
  assign ram_wdat     = req_segwdat;

  // Read-return shift register and error/status registers (stages 1..RDLAT+1)
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p          <= '0;
      res_segrdatvld <= 1'b0;
      res_segrdat    <= '0;
      outst          <= '0;
      err_sticky     <= 2'b00;
      intr           <= 8'h00;
    end else begin
      vld_p[0] <= acc_rd;
      for (int i = 1; i < RDLAT; i++) vld_p[i] <= vld_p[i-1];
      res_segrdatvld <= vld_p[RDLAT-1];
      if (vld_p[RDLAT-1]) res_segrdat <= resp_data(ezero_p[RDLAT-1], ram_rdat);
      outst      <= outst + CW'(acc_rd) - CW'(res_segrdatvld);
      err_sticky <= (err_sticky & ~{2{err_clr}}) | new_err;
      intr       <= {6'b000000, new_err};
    end
  end

  // Error-zero flag travels with the valid bit; it is only consumed when valid.
  always_ff @(posedge clk) begin
    ezero_p[0] <= any_err;
    for (int i = 1; i < RDLAT; i++) ezero_p[i] <= ezero_p[i-1];
  end

endmodule

// File: tb/tb_scedma_segresp.sv
// Bench for scedma_segresp: two instances (RDLAT=1 and RDLAT=2) share one
// stimulus stream and are checked against a transaction-level model.
module tb_scedma_segresp;
  localparam int AW = 12;
  localparam int DW = 32;
  localparam logic [1:0] PT_RO = 2'd0;
  localparam logic [1:0] PT_WO = 2'd1;
  localparam logic [1:0] PT_RW = 2'd2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, rd, wr, gnt, clr;
  logic [AW-1:0] segaddr, segsize, segptr;
  logic [DW-1:0] wdat;
  logic [1:0]    pt;

  logic          ready1, vld1, cs1, we1, ready2, vld2, cs2, we2;
  logic [DW-1:0] rdat1, wdat1, ramrd1, rdat2, wdat2, ramrd2, ramrd2a;
  logic [AW-1:0] addr1, addr2;
  logic [1:0]    sticky1, sticky2;
  logic [7:0]    intr1, intr2;

  scedma_segresp #(.AW(AW), .DW(DW), .RDLAT(1)) u_l1 (
    .clk(clk), .reset(rst), .req_segaddr(segaddr), .req_segsize(segsize),
    .req_segptr(segptr), .req_segrd(rd), .req_segwr(wr), .req_segwdat(wdat),
    .req_porttype(pt), .res_segready(ready1), .res_segrdat(rdat1),
    .res_segrdatvld(vld1), .ram_gnt(gnt), .ram_cs(cs1), .ram_we(we1),
    .ram_addr(addr1), .ram_wdat(wdat1), .ram_rdat(ramrd1), .err_clr(clr),
    .err_sticky(sticky1), .intr(intr1));

  scedma_segresp #(.AW(AW), .DW(DW), .RDLAT(2)) u_l2 (
    .clk(clk), .reset(rst), .req_segaddr(segaddr), .req_segsize(segsize),
    .req_segptr(segptr), .req_segrd(rd), .req_segwr(wr), .req_segwdat(wdat),
    .req_porttype(pt), .res_segready(ready2), .res_segrdat(rdat2),
    .res_segrdatvld(vld2), .ram_gnt(gnt), .ram_cs(cs2), .ram_we(we2),
    .ram_addr(addr2), .ram_wdat(wdat2), .ram_rdat(ramrd2), .err_clr(clr),
    .err_sticky(sticky2), .intr(intr2));

  function automatic logic [31:0] initval(input int a);
    logic [31:0] v;
    v = (32'(a) * 32'h9E3779B1) ^ 32'h5A5A0000;
    return (a == 32'h103) ? 32'hDEADBEEF : v;
  endfunction

  // RAM models with read latency 1 and 2
  logic [DW-1:0] mem1 [4096];
  logic [DW-1:0] mem2 [4096];
  bit mem_loaded = 0;
  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int a = 0; a < 4096; a++) begin
        mem1[a] = initval(a);
        mem2[a] = initval(a);
      end
      mem_loaded = 1;
    end
    if (cs1 && !we1) ramrd1 <= mem1[addr1];
    if (cs1 && we1) mem1[addr1] = wdat1;
    if (cs2 && !we2) ramrd2a <= mem2[addr2];
    ramrd2 <= ramrd2a;
    if (cs2 && we2) mem2[addr2] = wdat2;
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Transaction-level reference model, evaluated once per cycle on the falling edge
  typedef struct {
    int          port;
    int          due;
    logic [31:0] dat;
  } ret_t;
  ret_t sb[$];
  logic [DW-1:0] ref_mem [4096];
  bit   ref_loaded = 0;
  int   cyc = 0;
  logic [1:0] e_intr = 2'b00;
  logic [1:0] e_sticky = 2'b00;

  always @(negedge clk) begin
    logic any, berr, perr, err, due_now, full, e_ready, e_cs, e_we, acc0, wr0;
    logic a_ready, a_cs, a_we, a_vld;
    logic [AW-1:0] a_addr, addr;
    logic [DW-1:0] a_wdat, a_rdat;
    logic [1:0] a_sticky, newerr;
    logic [7:0] a_intr;
    int idx, outst, lat;
    if (!ref_loaded) begin
      for (int a = 0; a < 4096; a++) ref_mem[a] = initval(a);
      ref_loaded = 1;
    end
    any  = rd | wr;
    berr = (segptr >= segsize);
    perr = rd ? (pt == PT_WO) : (wr && pt == PT_RO);
    err  = any && (berr || perr);
    addr = AW'((32'(segaddr) + 32'(segptr)) % 4096);
    acc0 = 0;
    wr0  = 0;
    for (int k = 0; k < 2; k++) begin
      lat = k + 1;
      a_ready = k == 0 ? ready1 : ready2;
      a_cs = k == 0 ? cs1 : cs2;
      a_we = k == 0 ? we1 : we2;
      a_vld = k == 0 ? vld1 : vld2;
      a_addr = k == 0 ? addr1 : addr2;
      a_wdat = k == 0 ? wdat1 : wdat2;
      a_rdat = k == 0 ? rdat1 : rdat2;
      a_sticky = k == 0 ? sticky1 : sticky2;
      a_intr = k == 0 ? intr1 : intr2;
      idx = -1;
      outst = 0;
      foreach (sb[i]) if (sb[i].port == k) begin
        outst++;
        if (idx < 0) idx = i;
      end
      due_now = (idx >= 0) && (sb[idx].due == cyc);
      full = (outst == lat + 1) && !due_now;
      e_ready = !rst && any && (err || gnt) && !(rd && full);
      e_cs = e_ready && !err;
      e_we = e_cs && !rd;
      chk($sformatf("m%0d_ready", lat), 64'(a_ready), 64'(e_ready));
      chk($sformatf("m%0d_cs", lat), 64'(a_cs), 64'(e_cs));
      chk($sformatf("m%0d_we", lat), 64'(a_we), 64'(e_we));
      if (e_cs) chk($sformatf("m%0d_addr", lat), 64'(a_addr), 64'(addr));
      if (e_we) chk($sformatf("m%0d_wdat", lat), 64'(a_wdat), 64'(wdat));
      chk($sformatf("m%0d_rdatvld", lat), 64'(a_vld), 64'(due_now));
      if (due_now) begin
        chk($sformatf("m%0d_rdat", lat), 64'(a_rdat), 64'(sb[idx].dat));
        sb.delete(idx);
      end
      chk($sformatf("m%0d_intr", lat), 64'(a_intr), {62'd0, e_intr});
      chk($sformatf("m%0d_sticky", lat), 64'(a_sticky), {62'd0, e_sticky});
      if (e_ready && rd) sb.push_back('{k, cyc + lat + 1, err ? 32'h0 : ref_mem[addr]});
      if (k == 0) begin
        acc0 = e_ready;
        wr0  = e_we;
      end
    end
    if (rst) begin
      sb.delete();
      e_intr = 2'b00;
      e_sticky = 2'b00;
    end else begin
      newerr = acc0 ? {perr, berr} : 2'b00;
      e_intr = newerr;
      e_sticky = (e_sticky & ~{clr, clr}) | newerr;
      if (wr0) ref_mem[addr] = wdat;
    end
    cyc++;
  end

  typedef struct {
    logic rd, wr;
    logic [1:0] pt;
    logic [AW-1:0] ptr, size;
    logic gnt;
    logic exp_ready, exp_cs, exp_we;
  } vec_t;
  vec_t vt[12];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic r, input logic w, input logic [1:0] p,
                         input logic [AW-1:0] a, input logic [AW-1:0] s,
                         input logic [AW-1:0] o, input logic g, input logic [DW-1:0] d);
    rd = r; wr = w; pt = p; segaddr = a; segsize = s; segptr = o; gnt = g; wdat = d;
  endtask

  initial begin
    rst = 1; clr = 0;
    set_req(0, 0, PT_RW, 0, 0, 0, 0, 0);
    repeat (3) step();
    @(negedge clk);
    chk("rst_ready", 64'(ready1), 0);
    chk("rst_vld", 64'({vld1, vld2}), 0);
    chk("rst_cs_we", 64'({cs1, we1, cs2, we2}), 0);
    chk("rst_rdat", 64'(rdat1 | rdat2), 0);
    chk("rst_sticky_intr", 64'({sticky1, intr1, sticky2, intr2}), 0);
    step();
    rst = 0;
    step();

    // Read at 0x103, RDLAT=1 returns in cycle 2, RDLAT=2 in cycle 3
    set_req(1, 0, PT_RW, 12'h100, 12'd16, 12'd3, 1, 0);
    @(negedge clk);
    chk("rd_ready", 64'(ready1), 1);
    chk("rd_addr", 64'(addr1), 64'h103);
    chk("rd_cs_we", 64'({cs1, we1}), 64'b10);
    step(); rd = 0;
    @(negedge clk); chk("rd_vld_c1", 64'(vld1), 0);
    step();
    @(negedge clk);
    chk("rd_vld_c2", 64'(vld1), 1);
    chk("rd_rdat_c2", 64'(rdat1), 64'hDEADBEEF);
    step();
    @(negedge clk);
    chk("rd2_vld_c3", 64'(vld2), 1);
    chk("rd2_rdat_c3", 64'(rdat2), 64'hDEADBEEF);
    step();

    // Write held through a 3-cycle grant stall
    set_req(0, 1, PT_RW, 12'h100, 12'd16, 12'd5, 0, 32'h12345678);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("wr_stall_ready", 64'(ready1), 0);
      chk("wr_stall_cs", 64'(cs1), 0);
      step();
    end
    gnt = 1;
    @(negedge clk);
    chk("wr_ready", 64'(ready1), 1);
    chk("wr_cs_we", 64'({cs1, we1}), 64'b11);
    chk("wr_addr", 64'(addr1), 64'h105);
    chk("wr_wdat", 64'(wdat1), 64'h12345678);
    step(); wr = 0;
    step();

    // Simultaneous rd and wr: read first, write next cycle
    set_req(1, 1, PT_RW, 12'h100, 12'd16, 12'd3, 1, 32'hCAFEF00D);
    @(negedge clk);
    chk("rw_c0_ready", 64'(ready1), 1);
    chk("rw_c0_we", 64'(we1), 0);
    step(); rd = 0;
    @(negedge clk);
    chk("rw_c1_ready_we", 64'({ready1, we1}), 64'b11);
    step(); wr = 0;
    @(negedge clk);
    chk("rw_c2_vld", 64'(vld1), 1);
    chk("rw_c2_rdat", 64'(rdat1), 64'hDEADBEEF);
    step();

    // Bounds error read with no grant
    set_req(1, 0, PT_RW, 12'h100, 12'd16, 12'd16, 0, 0);
    @(negedge clk);
    chk("bnd_ready", 64'(ready1), 1);
    chk("bnd_cs", 64'(cs1), 0);
    step(); rd = 0;
    @(negedge clk);
    chk("bnd_intr", 64'(intr1), 64'h01);
    chk("bnd_sticky", 64'(sticky1), 64'b01);
    step();
    @(negedge clk);
    chk("bnd_vld", 64'(vld1), 1);
    chk("bnd_rdat", 64'(rdat1), 0);
    chk("bnd_intr_off", 64'(intr1), 0);
    step(); clr = 1;
    step(); clr = 0;
    @(negedge clk); chk("bnd_clr", 64'(sticky1), 0);
    step();

    // Port-type error write; then clear colliding with a new error
    set_req(0, 1, PT_RO, 12'h100, 12'd16, 12'd4, 1, 32'hFFFFFFFF);
    @(negedge clk);
    chk("pt_ready_cs", 64'({ready1, cs1}), 64'b10);
    step(); wr = 0;
    @(negedge clk);
    chk("pt_intr", 64'(intr1), 64'h02);
    chk("pt_sticky", 64'(sticky1), 64'b10);
    chk("pt_mem", 64'(mem1[12'h104]), 64'(initval(32'h104)));
    step(); clr = 1; wr = 1;
    step(); clr = 0; wr = 0;
    @(negedge clk); chk("clr_vs_err", 64'(sticky1), 64'b10);
    step(); clr = 1;
    step(); clr = 0;
    step();

    // Single-cycle acceptance table
    vt[0]  = '{1, 0, PT_RW, 12'd2, 12'd8, 1, 1, 1, 0};
    vt[1]  = '{1, 0, PT_RW, 12'd2, 12'd8, 0, 0, 0, 0};
    vt[2]  = '{0, 1, PT_RW, 12'd2, 12'd8, 1, 1, 1, 1};
    vt[3]  = '{0, 1, PT_RW, 12'd2, 12'd8, 0, 0, 0, 0};
    vt[4]  = '{1, 0, PT_WO, 12'd2, 12'd8, 0, 1, 0, 0};
    vt[5]  = '{0, 1, PT_RO, 12'd2, 12'd8, 1, 1, 0, 0};
    vt[6]  = '{1, 0, PT_RO, 12'd8, 12'd8, 0, 1, 0, 0};
    vt[7]  = '{0, 1, PT_WO, 12'd7, 12'd8, 1, 1, 1, 1};
    vt[8]  = '{1, 1, PT_RW, 12'd3, 12'd8, 1, 1, 1, 0};
    vt[9]  = '{0, 0, PT_RW, 12'd3, 12'd8, 1, 0, 0, 0};
    vt[10] = '{0, 1, PT_RO, 12'd9, 12'd8, 1, 1, 0, 0};
    vt[11] = '{1, 0, PT_RO, 12'd0, 12'd0, 1, 1, 0, 0};
    for (int i = 0; i < 12; i++) begin
      set_req(vt[i].rd, vt[i].wr, vt[i].pt, 12'h200, vt[i].size, vt[i].ptr, vt[i].gnt, 32'hA0000000 + 32'(i));
      @(negedge clk);
      chk($sformatf("vec%0d_ready", i), 64'({ready1, ready2}), 64'({vt[i].exp_ready, vt[i].exp_ready}));
      chk($sformatf("vec%0d_cs_we", i), 64'({cs1, we1}), 64'({vt[i].exp_cs, vt[i].exp_we}));
      step();
    end
    set_req(0, 0, PT_RW, 0, 0, 0, 0, 0);
    repeat (4) step();

    // Streaming 8 reads on the RDLAT=2 instance
    for (int c = 0; c < 13; c++) begin
      set_req(c < 8, 0, PT_RW, 12'h300, 12'd64, AW'(c), 1, 0);
      @(negedge clk);
      if (c < 8) chk($sformatf("strm_ready_c%0d", c), 64'(ready2), 1);
      chk($sformatf("strm_vld2_c%0d", c), 64'(vld2), 64'((c >= 3) && (c <= 10)));
      step();
    end

    // Reset asserted after the 4th accepted read flushes the pipelines
    for (int c = 0; c < 10; c++) begin
      set_req(c < 6, 0, PT_RW, 12'h300, 12'd64, AW'(c), 1, 0);
      rst = (c == 4) || (c == 5);
      @(negedge clk);
      if (c == 4 || c == 5) chk($sformatf("rstm_ready_c%0d", c), 64'({ready1, ready2, cs1, cs2}), 0);
      if (c >= 5) chk($sformatf("rstm_vld_c%0d", c), 64'({vld1, vld2}), 0);
      if (c == 6) begin
        chk("rstm_rdat", 64'(rdat1 | rdat2), 0);
        chk("rstm_status", 64'({sticky1, intr1, sticky2, intr2}), 0);
      end
      step();
    end
    rst = 0;

    // Randomized traffic checked by the model
    for (int n = 0; n < 2000; n++) begin
      set_req($urandom_range(0, 99) < 40, $urandom_range(0, 99) < 35, 2'($urandom_range(0, 2)),
              AW'($urandom), AW'($urandom_range(0, 20)), AW'($urandom_range(0, 22)),
              $urandom_range(0, 99) < 70, $urandom);
      clr = $urandom_range(0, 99) < 10;
      rst = $urandom_range(0, 199) == 0;
      step();
    end
    set_req(0, 0, PT_RW, 0, 0, 0, 0, 0);
    clr = 0; rst = 0;
    repeat (6) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/scedma_segresp.md
Name: scedma_segresp

Overview:
- Responder end of the scedma segment request/response interface.
- Accepts segment-relative read/write requests from one DMA channel port and converts them into accesses on a single-port synchronous RAM (or shared-RAM arbiter) port.
- Returns ready, read data and read-data-valid to the channel.
- Enforces segment bounds and port-type permissions, and flags violations without hanging the initiator.

Parameters:
AW, 12, RAM word-address width; segaddr, segptr and segsize share this width.
DW, 32, data width.
RDLAT, 1, RAM read latency in cycles after the cs cycle; legal values 1 or 2.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
req_segaddr  in  AW  segment base word address
req_segsize  in  AW  segment size in words
req_segptr  in  AW  word offset within segment
req_segrd  in  1  read request, held until res_segready
req_segwr  in  1  write request, held until res_segready
req_segwdat  in  DW  write data
req_porttype  in  2  PT_RO / PT_WO / PT_RW (scedma_pkg encoding)
res_segready  out  1  request accepted this cycle
res_segrdat  out  DW  read data
res_segrdatvld  out  1  one-cycle pulse qualifying res_segrdat
ram_gnt  in  1  RAM port available this cycle
ram_cs  out  1  RAM chip select
ram_we  out  1  RAM write enable
ram_addr  out  AW  RAM word address
ram_wdat  out  DW  RAM write data
ram_rdat  in  DW  RAM read data, valid RDLAT cycles after cs&~we
err_clr  in  1  clears err_sticky
err_sticky  out  2  [0] bounds error seen, [1] port-type error seen
intr  out  8  [0] bounds-error pulse, [1] port-type-error pulse, [7:2]=0

Behaviour:
- Reset values: res_segready, res_segrdatvld, ram_cs, ram_we, err_sticky and intr are 0; res_segrdat is 0; the read pipeline is empty.
- Address: ram_addr = req_segaddr + req_segptr, modulo 2^AW.
- Request selection:
  - rd has priority over wr when both are asserted.
  - A stalled wr is accepted on a later cycle when rd is low; it is never dropped.
- Ready rule:
  - res_segready is combinational and asserts in the same cycle as the request.
  - Condition: (rd|wr) & ram_gnt & pipeline-not-full, or (rd|wr) & error-condition.
  - With ram_gnt=0 and no error, res_segready=0 and ram_cs=0.
- Bounds error: req_segptr >= req_segsize.
  - No RAM access (ram_cs=0).
  - Ready asserts regardless of ram_gnt.
  - A read still returns res_segrdat=0 with res_segrdatvld, at the normal latency.
  - err_sticky[0] sets; intr[0] pulses for one cycle.
- Port-type error: rd with PT_WO, or wr with PT_RO.
  - Handled the same way as a bounds error (no RAM access, ready asserts, read returns 0).
  - err_sticky[1] sets; intr[1] pulses.
  - If both errors occur together, both bits set.
- Write path: accepted write drives ram_cs=1, ram_we=1, ram_wdat=req_segwdat in the accept cycle. No response pulse is returned.
- Read pipeline:
  - Shift register of depth RDLAT+1 carrying {valid, error-zero} bits.
  - An accepted read returns res_segrdatvld exactly RDLAT+1 cycles after the accept cycle.
  - res_segrdat is registered from ram_rdat, or forced to 0 for error reads.
  - res_segrdatvld pulses are in accept order.
- Outstanding reads: at most RDLAT+1 in flight (the outstanding counter). Reads block when the counter equals RDLAT+1, unless a return pulse completes in the same cycle.
- Back-to-back reads: one accept per cycle is sustained when ram_gnt=1, and returns arrive on consecutive cycles.
- err_sticky:
  - Held until err_clr.
  - err_clr and a new error in the same cycle: the new error wins and the bit stays set.
- Reset mid-operation: the in-flight pipeline is flushed. No res_segrdatvld appears after reset deasserts for reads accepted before it.

Test Plan:
- Read, RDLAT=1: segaddr=0x100, segptr=3, segsize=16, ram holds 0xDEADBEEF at 0x103, gnt=1 → ready in cycle 0, ram_addr=0x103, rdatvld pulse in cycle 2 with rdat=0xDEADBEEF.
- Write then stalled grant:
  - wr with ptr=5, wdat=0x12345678, gnt=0 for 3 cycles then 1 → ready=0 for 3 cycles.
  - In cycle 3: ready=1, cs=1, we=1, addr=0x105.
- Simultaneous rd and wr (PT_RW):
  - Cycle 0: read accepted first, we=0.
  - Cycle 1 (rd deasserted): write accepted.
  - The read data returns unaffected.
- Bounds error: ptr=16, segsize=16, rd → ready in cycle 0 with gnt=0, cs=0, rdatvld in cycle 2 with rdat=0, intr[0] pulse, err_sticky=01. Then err_clr → 00.
- Port-type error: wr with PT_RO → ready=1, cs=0, intr[1] pulse, err_sticky=10, RAM contents unchanged.
- Streaming plus reset, RDLAT=2: 8 consecutive reads with gnt=1 → 8 consecutive rdatvld pulses starting 3 cycles after the first accept. Asserting reset after the 4th accept → no further rdatvld, all outputs 0.
